vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. It watches the Hsync/Vsync pair a generator drives, measures line and frame lengths, and locks once the measured timing matches the configured mode. When locked, it regenerates pixel coordinates and an active-video flag. Downstream consumers are a frame grabber/checker on the display path and the loopback self-test of the OV7670 frame pipeline.

## Interface
Parameters:
- H_TOTAL, 800: clocks per line.
- V_TOTAL, 525: lines per frame.
- H_ACT_START, 144: clocks from the Hsync fall to the first active pixel (sync pulse plus back porch).
- V_ACT_START, 35: lines from the Vsync fall to the first active line.
- H_ACT, 640: active pixels per line.
- V_ACT, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive good frames required to lock (1..7).

Ports:
- CLK25 in 1: pixel clock. All logic runs on its rising edge.
- Nreset in 1: asynchronous, active-low reset.
- Hsync in 1: horizontal sync, active low, synchronous to CLK25.
- Vsync in 1: vertical sync, active low, synchronous to CLK25.
- Nblank in 1: active video, high during visible area. Used only by the blank check.
- pix_x out 10: active-area column, 0..H_ACT-1. Held at 0 outside the active area.
- pix_y out 10: active-area row, 0..V_ACT-1. Held at 0 outside the active area.
- active out 1: high when locked and inside the active window.
- lock out 1: timing locked.
- frame_start out 1: one-cycle pulse on each Vsync fall while locked.
- err out 1: one-cycle pulse on any timing mismatch.
- h_meas out 10: last measured line length minus 1.
- v_meas out 10: last measured frame length in lines minus 1.

## Operation
- Front end:
  - Hsync and Vsync each pass through a 2-flop stage (d1, d2).
  - Fall = d2 & ~d1.
  - Registers reset to 1.
- hcnt:
  - Cleared on an Hsync fall, otherwise incremented.
  - Saturates at 1023.
- vcnt:
  - Cleared on a Vsync fall.
  - Incremented on an Hsync fall.
  - Saturates at 1023.
- Measurement:
  - On an Hsync fall, h_meas <= hcnt (nominal H_TOTAL-1).
  - On a Vsync fall, v_meas <= vcnt (nominal V_TOTAL-1).
- Simultaneous Hsync and Vsync fall: both counters clear, and v_meas captures vcnt before the clear.
- State machine, in the shared package:
  - SEARCH: the next Vsync fall moves to MEASURE with good = 0.
  - MEASURE: on each Vsync fall, if the frame was good then good++, else good = 0. A frame is good when v_meas matches and every line in the frame matched h_meas. When good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED:
    - An Hsync fall with hcnt ≠ H_TOTAL-1 causes a mismatch.
    - A Vsync fall with vcnt ≠ V_TOTAL-1 causes a mismatch.
    - hcnt reaching 1023 causes a mismatch.
    - On a mismatch: err pulse, lock <= 0, go to MEASURE with good = 0.
- The first Vsync fall after SEARCH only starts the measurement and is not judged.
- The frame-good flag resets on every Vsync fall.
- Active window: hcnt in [H_ACT_START, H_ACT_START+H_ACT) and vcnt in [V_ACT_START, V_ACT_START+V_ACT).
- pix_x = hcnt - H_ACT_START and pix_y = vcnt - V_ACT_START, both 10-bit, valid only inside the window.

## Timing
- Reset values:
  - All outputs 0.
  - State SEARCH; hcnt, vcnt and good 0; sync flops 1.
  - Reset is asynchronous. Deassertion mid-frame restarts from SEARCH.
- Sync latency:
  - A first low sample at edge k is detected as a fall in the cycle after k.
  - hcnt = 0 after edge k+1.
- Outputs are registered, one cycle after the counters:
  - pix_x = 0 and active rise after edge k+2+H_ACT_START.
  - lock, err and frame_start are asserted one cycle after the detecting Vsync/Hsync fall.
- err and frame_start are exactly one cycle wide.
- A mismatch and a Vsync fall in the same cycle produce one err pulse and no frame_start.

## Configuration
- VGA_SYNC_DEC_BLANK_CHECK_EN:
  - Defined: while LOCKED, the Nblank input (delayed 2 cycles to match the front end) is compared with the internal window. Any difference pulses err, but lock is kept.
  - Undefined: Nblank is ignored, and err comes only from sync timing.

## Structure
- vga_sync_pkg holds:
  - the state enum (SEARCH, MEASURE, LOCKED);
  - the default timing constants for 640x480, shared with the generator's parameters;
  - the 10-bit counter width constant.
- One sub-module, vga_edge_det: the 2-flop fall detector with async active-low reset, instantiated for Hsync and Vsync.

## Test plan
- Nominal 800x525 timing from the generator for 4 frames:
  - lock rises one cycle after the 3rd Vsync fall.
  - h_meas = 799, v_meas = 524.
  - pix_x/pix_y step 0..639 / 0..479.
  - active is high for 640 cycles per active line.
- After lock, one line stretched to 801 clocks:
  - single err pulse and lock = 0.
  - Relock occurs after 2 subsequent good frames.
- Hsync stuck high while locked: hcnt saturates at 1023, then err pulses and lock = 0.
- One 524-line frame while locked: err at that Vsync fall, v_meas = 523.
- Nreset pulsed low mid-line while locked: all outputs are 0 immediately and state is SEARCH. Lock returns after 3 Vsync falls.
- With VGA_SYNC_DEC_BLANK_CHECK_EN defined, Nblank forced low at pix_x = 100: one err pulse and lock stays 1. Without the macro: no err.

Source files
------------

// File: rtl/vga_sync_pkg.sv
// Shared definitions for the VGA sync decoder: lock-state enum, default 640x480 timing and the
// counter width.
package vga_sync_pkg;

  localparam int unsigned CntW = 10;

  localparam int unsigned DefHTotal     = 800;
  localparam int unsigned DefVTotal     = 525;
  localparam int unsigned DefHActStart  = 144;
  localparam int unsigned DefVActStart  = 35;
  localparam int unsigned DefHAct       = 640;
  localparam int unsigned DefVAct       = 480;
  localparam int unsigned DefLockFrames = 2;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StLocked
  } sync_state_e;

  // Half-open range test [lo, hi) on counter-width values.
  function automatic logic in_span(logic [CntW-1:0] val, logic [CntW-1:0] lo,
                                   logic [CntW-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and decoded timing outputs of the VGA sync decoder.
interface vga_sync_decoder_if;
  import vga_sync_pkg::*;

  logic            Hsync;
  logic            Vsync;
  logic            Nblank;
  logic [CntW-1:0] pix_x;
  logic [CntW-1:0] pix_y;
  logic            active;
  logic            lock;
  logic            frame_start;
  logic            err;
  logic [CntW-1:0] h_meas;
  logic [CntW-1:0] v_meas;

  modport master (
    output Hsync, Vsync, Nblank,
    input  pix_x, pix_y, active, lock, frame_start, err, h_meas, v_meas
  );

  modport slave (
    input  Hsync, Vsync, Nblank,
    output pix_x, pix_y, active, lock, frame_start, err, h_meas, v_meas
  );

endinterface

// File: rtl/vga_edge_det.sv
// Two-flop front end for an active-low sync line; flags the cycle after the first low sample.
module vga_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic fall_o
);

  logic d1_q, d2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1_q <= 1'b1;
      d2_q <= 1'b1;
    end else begin
      d1_q <= sync_i;
      d2_q <= d1_q;
    end
  end

  assign fall_o = d2_q & ~d1_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Measures Hsync/Vsync timing, locks onto the configured mode and regenerates pixel coordinates.
// Optional Nblank cross-check while locked: define VGA_SYNC_DEC_BLANK_CHECK_EN.
module vga_sync_decoder
  import vga_sync_pkg::*;
#(
  parameter int unsigned H_TOTAL     = DefHTotal,
  parameter int unsigned V_TOTAL     = DefVTotal,
  parameter int unsigned H_ACT_START = DefHActStart,
  parameter int unsigned V_ACT_START = DefVActStart,
  parameter int unsigned H_ACT       = DefHAct,
  parameter int unsigned V_ACT       = DefVAct,
  parameter int unsigned LOCK_FRAMES = DefLockFrames
) (
  input logic               CLK25,
  input logic               Nreset,
  vga_sync_decoder_if.slave vga_io
);

  localparam logic [CntW-1:0] HLast     = CntW'(H_TOTAL - 1);
  localparam logic [CntW-1:0] VLast     = CntW'(V_TOTAL - 1);
  localparam logic [CntW-1:0] HActStart = CntW'(H_ACT_START);
  localparam logic [CntW-1:0] VActStart = CntW'(V_ACT_START);
  localparam logic [CntW-1:0] HActEnd   = CntW'(H_ACT_START + H_ACT);
  localparam logic [CntW-1:0] VActEnd   = CntW'(V_ACT_START + V_ACT);
  localparam logic [CntW-1:0] CntAll    = '1;
  localparam logic [2:0]      LockGood  = 3'(LOCK_FRAMES);

  logic h_fall, v_fall;

  vga_edge_det u_h_det (
    .clk_i  (CLK25),
    .rst_ni (Nreset),
    .sync_i (vga_io.Hsync),
    .fall_o (h_fall)
  );

  vga_edge_det u_v_det (
    .clk_i  (CLK25),
    .rst_ni (Nreset),
    .sync_i (vga_io.Vsync),
    .fall_o (v_fall)
  );

  logic [CntW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, h_meas_q, v_meas_q;
  logic            h_sat;

  assign h_sat = (hcnt_q == CntAll);

  always_comb begin
    hcnt_d = h_sat ? hcnt_q : hcnt_q + 1'b1;
    if (h_fall) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (v_fall) begin
      vcnt_d = '0;
    end else if (h_fall && (vcnt_q != CntAll)) begin
      vcnt_d = vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      h_meas_q <= '0;
      v_meas_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (h_fall) h_meas_q <= hcnt_q;
      if (v_fall) v_meas_q <= vcnt_q;
    end
  end

  logic win;
  assign win = in_span(hcnt_q, HActStart, HActEnd) && in_span(vcnt_q, VActStart, VActEnd);

  sync_state_e state_q;
  logic [2:0]  good_q, good_inc;
  logic        frame_bad_q, frame_bad_d, line_bad, frame_ok, mism, blank_err;
  logic        lock_q, err_q, fs_q;

  // The line closed by a coincident Hsync fall still belongs to the frame being judged.
  assign line_bad    = (h_fall && (hcnt_q != HLast)) || h_sat;
  assign frame_ok    = !frame_bad_q && !line_bad && (vcnt_q == VLast);
  assign frame_bad_d = v_fall ? 1'b0 : (frame_bad_q | line_bad);
  assign good_inc    = good_q + 3'd1;
  assign mism        = (h_fall && (hcnt_q != HLast)) || (v_fall && (vcnt_q != VLast)) || h_sat;

`ifdef VGA_SYNC_DEC_BLANK_CHECK_EN
  logic nb_d1_q, nb_d2_q;

  // Two stages so Nblank lines up with the counters behind the sync front end.
  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      nb_d1_q <= 1'b0;
      nb_d2_q <= 1'b0;
    end else begin
      nb_d1_q <= vga_io.Nblank;
      nb_d2_q <= nb_d1_q;
    end
  end

  assign blank_err = (nb_d2_q != win);
`else
  logic unused_nblank;
  assign unused_nblank = vga_io.Nblank;
  assign blank_err     = 1'b0;
`endif

  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      state_q     <= StSearch;
      good_q      <= '0;
      frame_bad_q <= 1'b0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      fs_q        <= 1'b0;
      frame_bad_q <= frame_bad_d;
      unique case (state_q)
        StSearch: begin
          if (v_fall) begin
            state_q <= StMeasure;
            good_q  <= '0;
          end
        end
        StMeasure: begin
          if (v_fall) begin
            if (!frame_ok) begin
              good_q <= '0;
            end else if (good_inc == LockGood) begin
              good_q  <= good_inc;
              state_q <= StLocked;
              lock_q  <= 1'b1;
            end else begin
              good_q <= good_inc;
            end
          end
        end
        StLocked: begin
          if (mism) begin
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            state_q <= StMeasure;
            good_q  <= '0;
          end else begin
            err_q <= blank_err;
            fs_q  <= v_fall;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  logic [CntW-1:0] pix_x_q, pix_y_q;
  logic            active_q;

  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      active_q <= 1'b0;
    end else begin
      pix_x_q  <= win ? hcnt_q - HActStart : '0;
      pix_y_q  <= win ? vcnt_q - VActStart : '0;
      active_q <= win && (state_q == StLocked);
    end
  end

  assign vga_io.pix_x       = pix_x_q;
  assign vga_io.pix_y       = pix_y_q;
  assign vga_io.active      = active_q;
  assign vga_io.lock        = lock_q;
  assign vga_io.frame_start = fs_q;
  assign vga_io.err         = err_q;
  assign vga_io.h_meas      = h_meas_q;
  assign vga_io.v_meas      = v_meas_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled 100x12 mode so each frame is 1200 clocks.
module tb_vga_sync_decoder;

  localparam int HT  = 100;
  localparam int VT  = 12;
  localparam int HAS = 18;
  localparam int VAS = 3;
  localparam int HA  = 80;
  localparam int VA  = 8;
  localparam int HSW = 12;
  localparam int VSW = 2;
  localparam int FR  = HT * VT;

  logic clk, rst_n;
  vga_sync_decoder_if vga ();

  vga_sync_decoder #(
    .H_TOTAL     (HT),
    .V_TOTAL     (VT),
    .H_ACT_START (HAS),
    .V_ACT_START (VAS),
    .H_ACT       (HA),
    .V_ACT       (VA),
    .LOCK_FRAMES (2)
  ) dut (
    .CLK25  (clk),
    .Nreset (rst_n),
    .vga_io (vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Generator position and knobs
  int hc = 0, vc = 0, h_len = HT, v_len = VT;
  bit gen_en = 0, gen_started = 0, kill_h = 0, blank_kill = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int neg_idx = 0, vf_cnt = 0, last_vf_neg = 0, last_hf_neg = 0;
  int hist_h[3] = '{-1, -1, -1};
  int hist_v[3] = '{-1, -1, -1};

  // Observations
  int err_cnt = 0, err_wide = 0, err_neg = 0, fs_cnt = 0, fs_delta = 0;
  int lock_vf = 0, lock_delta = 0, pix_bad = 0, act_cnt = 0;
  logic err_prev = 1'b0, lock_prev = 1'b0;
  bit chk_pix = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic       w;
    logic [9:0] ex_x, ex_y;
    if (vga.err) begin
      err_cnt++;
      err_neg = neg_idx;
      if (err_prev) err_wide++;
    end
    if (vga.frame_start) begin
      fs_cnt++;
      fs_delta = neg_idx - last_vf_neg;
    end
    if (vga.lock && !lock_prev) begin
      lock_vf    = vf_cnt;
      lock_delta = neg_idx - last_vf_neg;
    end
    if (chk_pix) begin
      // Outputs trail the driven position by three negedges.
      w = (hist_h[2] >= HAS) && (hist_h[2] < HAS + HA) && (hist_v[2] >= VAS) &&
          (hist_v[2] < VAS + VA);
      ex_x = w ? 10'(hist_h[2] - HAS) : 10'd0;
      ex_y = w ? 10'(hist_v[2] - VAS) : 10'd0;
      if (vga.active !== w || vga.pix_x !== ex_x || vga.pix_y !== ex_y) pix_bad++;
      if (vga.active) act_cnt++;
    end
    err_prev  = vga.err;
    lock_prev = vga.lock;
  endtask

  task automatic drive_pins();
    logic hs, vs, nb;
    if (!gen_en) begin
      hs = 1'b1;
      vs = 1'b1;
      nb = 1'b0;
    end else begin
      hs = !(hc < HSW) || kill_h;
      vs = !(vc < VSW);
      nb = (hc >= HAS) && (hc < HAS + HA) && (vc >= VAS) && (vc < VAS + VA) && !kill_h &&
           !blank_kill;
    end
    if (!hs && hs_prev) last_hf_neg = neg_idx;
    if (!vs && vs_prev) begin
      vf_cnt++;
      last_vf_neg = neg_idx;
    end
    hs_prev    = hs;
    vs_prev    = vs;
    vga.Hsync  = hs;
    vga.Vsync  = vs;
    vga.Nblank = nb;
    hist_h[2]  = hist_h[1];
    hist_h[1]  = hist_h[0];
    hist_h[0]  = gen_en ? hc : -1;
    hist_v[2]  = hist_v[1];
    hist_v[1]  = hist_v[0];
    hist_v[0]  = gen_en ? vc : -1;
  endtask

  task automatic step();
    @(negedge clk);
    neg_idx++;
    monitor();
    if (gen_en) begin
      if (gen_started) begin
        hc++;
        if (hc >= h_len) begin
          hc    = 0;
          h_len = HT;
          vc++;
          if (vc >= v_len) begin
            vc    = 0;
            v_len = VT;
          end
        end
      end
      gen_started = 1;
    end
    drive_pins();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(hc == h && vc == v) && n < 3 * FR);
    if (!(hc == h && vc == v)) check_eq("run_to_bound", n, -1);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_pix_x"}, int'(vga.pix_x), 0);
    check_eq({pfx, "_pix_y"}, int'(vga.pix_y), 0);
    check_eq({pfx, "_active"}, int'(vga.active), 0);
    check_eq({pfx, "_lock"}, int'(vga.lock), 0);
    check_eq({pfx, "_frame_start"}, int'(vga.frame_start), 0);
    check_eq({pfx, "_err"}, int'(vga.err), 0);
    check_eq({pfx, "_h_meas"}, int'(vga.h_meas), 0);
    check_eq({pfx, "_v_meas"}, int'(vga.v_meas), 0);
  endtask

  initial begin
    int e0, fs0, vb, ev_at, exp_blank_err;
    rst_n      = 1'b0;
    vga.Hsync  = 1'b1;
    vga.Vsync  = 1'b1;
    vga.Nblank = 1'b0;
    run(3);
    check_all_zero("reset");

    // Nominal timing: lock one cycle after the 3rd detected Vsync fall
    rst_n  = 1'b1;
    gen_en = 1;
    run(2 * FR + 10);
    check_eq("lock_after_vf", lock_vf, 3);
    check_eq("lock_latency", lock_delta, 2);
    check_eq("lock_nominal", int'(vga.lock), 1);
    run_to(VT - 1, HT - 1);
    chk_pix = 1;
    act_cnt = 0;
    pix_bad = 0;
    fs0     = fs_cnt;
    run(FR);
    chk_pix = 0;
    check_eq("pix_trace", pix_bad, 0);
    check_eq("active_cycles", act_cnt, HA * VA);
    check_eq("frame_start_cnt", fs_cnt - fs0, 1);
    check_eq("frame_start_latency", fs_delta, 2);
    check_eq("h_meas", int'(vga.h_meas), HT - 1);
    check_eq("v_meas", int'(vga.v_meas), VT - 1);
    check_eq("nominal_no_err", err_cnt, 0);

    // One line stretched by a clock
    run_to(5, 30);
    e0    = err_cnt;
    vb    = vf_cnt;
    h_len = HT + 1;
    run_to(6, 0);
    ev_at = neg_idx;
    run(5);
    check_eq("stretch_err_cnt", err_cnt - e0, 1);
    check_eq("stretch_err_latency", err_neg - ev_at, 2);
    check_eq("stretch_unlock", int'(vga.lock), 0);
    check_eq("stretch_h_meas", int'(vga.h_meas), HT);
    repeat (3) run_to(0, 0);
    run(5);
    check_eq("stretch_relock", int'(vga.lock), 1);
    check_eq("stretch_relock_vf", lock_vf - vb, 3);

    // Hsync stuck high for the rest of a frame
    run_to(0, 50);
    e0     = err_cnt;
    ev_at  = last_hf_neg;
    kill_h = 1;
    run_to(VT - 1, HT - 1);
    kill_h = 0;
    check_eq("stuck_err_cnt", err_cnt - e0, 1);
    check_eq("stuck_err_latency", err_neg - ev_at, 1026);
    check_eq("stuck_unlock", int'(vga.lock), 0);
    vb = vf_cnt;
    repeat (3) run_to(0, 0);
    run(5);
    check_eq("stuck_relock", int'(vga.lock), 1);
    check_eq("stuck_relock_vf", lock_vf - vb, 3);

    // One frame a line short
    e0    = err_cnt;
    fs0   = fs_cnt;
    vb    = vf_cnt;
    v_len = VT - 1;
    run_to(0, 0);
    ev_at = neg_idx;
    run(5);
    check_eq("short_err_cnt", err_cnt - e0, 1);
    check_eq("short_err_latency", err_neg - ev_at, 2);
    check_eq("short_no_frame_start", fs_cnt - fs0, 0);
    check_eq("short_v_meas", int'(vga.v_meas), VT - 2);
    check_eq("short_unlock", int'(vga.lock), 0);
    repeat (2) run_to(0, 0);
    run(5);
    check_eq("short_relock", int'(vga.lock), 1);
    check_eq("short_relock_vf", lock_vf - vb, 3);

    // Asynchronous reset pulse mid-line
    run_to(5, 40);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    #1 rst_n = 1'b1;
    vb = vf_cnt;
    run(5);
    check_eq("midreset_still_unlocked", int'(vga.lock), 0);
    repeat (3) run_to(0, 0);
    run(5);
    check_eq("midreset_relock", int'(vga.lock), 1);
    check_eq("midreset_relock_vf", lock_vf - vb, 3);
    check_eq("midreset_relock_latency", lock_delta, 2);

    // Nblank dropped for one cycle at pix_x = 40 on a locked line
`ifdef VGA_SYNC_DEC_BLANK_CHECK_EN
    exp_blank_err = 1;
`else
    exp_blank_err = 0;
`endif
    run_to(5, HAS + 39);
    e0         = err_cnt;
    blank_kill = 1;
    step();
    blank_kill = 0;
    run(10);
    check_eq("blank_err_cnt", err_cnt - e0, exp_blank_err);
    check_eq("blank_keeps_lock", int'(vga.lock), 1);
    check_eq("err_single_cycle", err_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
